// File: rtl/write_merge_buffer_pkg.sv
// write_merge_buffer_pkg: shared line types and buffer state encoding
package write_merge_buffer_pkg;
  typedef logic [127:0] lc3b_line;
  typedef logic [15:0] lc3b_line_mask;
  typedef logic [11:0] lc3b_line_tag;
  typedef enum logic [1:0] {WMB_EMPTY, WMB_MERGING, WMB_DRAIN} wmb_state_t;
endpackage

// File: rtl/write_merge_buffer_line_byte_merge.sv
// line_byte_merge: inserts a masked store word into a line image at a byte offset
module line_byte_merge #(
  parameter int LINE_BYTES = 16,
  parameter int WORD_BYTES = 2,
  localparam int OFF_W = $clog2(LINE_BYTES)
) (
  input  logic [OFF_W-1:0]        offset,
  input  logic [8*LINE_BYTES-1:0] line,
  input  logic [LINE_BYTES-1:0]   mask,
  input  logic [8*WORD_BYTES-1:0] word,
  input  logic [WORD_BYTES-1:0]   wmask,
  output logic [8*LINE_BYTES-1:0] merged_line,
  output logic [LINE_BYTES-1:0]   merged_mask
);
  logic [LINE_BYTES-1:0] wide_mask;
  logic [8*LINE_BYTES-1:0] wide_word;
  // bytes shifted past the line end fall off, so there is no wrap
  assign wide_mask = LINE_BYTES'(wmask) << offset;
  assign wide_word = (8*LINE_BYTES)'(word) << {offset, 3'b000};
  for (genvar g = 0; g < LINE_BYTES; g++) begin : g_byte
    assign merged_line[8*g +: 8] = wide_mask[g] ? wide_word[8*g +: 8] : line[8*g +: 8];
    assign merged_mask[g] = mask[g] | wide_mask[g];
  end
endmodule

// File: rtl/write_merge_buffer.sv
// write_merge_buffer: coalesces sub-line stores into one line write, drained on tag change, flush or idle timeout
module write_merge_buffer
  import write_merge_buffer_pkg::*;
#(
  parameter int LINE_BYTES = 16,
  parameter int WORD_BYTES = 2,
  parameter int ADDR_W = 16,
  parameter int TIMEOUT = 16,
  localparam int OFF_W = $clog2(LINE_BYTES),
  localparam int TAG_W = ADDR_W - OFF_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [8*WORD_BYTES-1:0] in_word,
  input  logic [WORD_BYTES-1:0]   in_wmask,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TAG_W-1:0]        out_tag,
  output logic [8*LINE_BYTES-1:0] out_data,
  output logic [LINE_BYTES-1:0]   out_bmask,
  output logic                    empty
);
  localparam int CNT_W = $clog2(TIMEOUT + 2);
  wmb_state_t state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d, in_tag;
  logic [8*LINE_BYTES-1:0] data_q, data_d, base_line, merged_line;
  logic [LINE_BYTES-1:0] mask_q, mask_d, base_mask, merged_mask;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OFF_W-1:0] in_off;
  logic store, timeout_hit;
  assign in_tag = in_addr[ADDR_W-1:OFF_W];
  assign in_off = in_addr[OFF_W-1:0];
  // allocation starts from a clean line rather than the stale image
  assign base_line = state_q == WMB_EMPTY ? '0 : data_q;
  assign base_mask = state_q == WMB_EMPTY ? '0 : mask_q;
  line_byte_merge #(.LINE_BYTES(LINE_BYTES), .WORD_BYTES(WORD_BYTES)) u_merge (
    .offset(in_off),
    .line(base_line),
    .mask(base_mask),
    .word(in_word),
    .wmask(in_wmask),
    .merged_line(merged_line),
    .merged_mask(merged_mask)
  );
  assign in_ready = reset_n && (state_q == WMB_EMPTY || (state_q == WMB_MERGING && in_tag == tag_q));
  assign store = in_valid && in_ready && |in_wmask;
  assign timeout_hit = TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT);
  always_comb begin
    tag_d = store ? in_tag : tag_q;
    data_d = store ? merged_line : data_q;
    mask_d = store ? merged_mask : mask_q;
    cnt_d = store ? '0 : cnt_q == CNT_W'(TIMEOUT) ? cnt_q : cnt_q + 1'b1;
    state_d = state_q == WMB_EMPTY ? (store ? (flush ? WMB_DRAIN : WMB_MERGING) : WMB_EMPTY) :
              state_q == WMB_MERGING ? ((flush || timeout_hit || (in_valid && !in_ready)) ? WMB_DRAIN : WMB_MERGING) :
              (out_ready ? WMB_EMPTY : WMB_DRAIN);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= WMB_EMPTY;
      tag_q <= '0;
      data_q <= '0;
      mask_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q <= tag_d;
      data_q <= data_d;
      mask_q <= mask_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_valid = state_q == WMB_DRAIN;
  assign empty = state_q == WMB_EMPTY;
  assign out_tag = tag_q;
  assign out_data = data_q;
  assign out_bmask = mask_q;
endmodule

// File: tb/tb_write_merge_buffer.sv
// tb_write_merge_buffer: directed stores with a drain scoreboard checked by an independent monitor
module tb_write_merge_buffer;
  import write_merge_buffer_pkg::*;
  typedef struct packed {
    lc3b_line_tag tag;
    lc3b_line data;
    lc3b_line_mask bmask;
  } exp_t;
  logic clk = 0, reset_n = 0, in_valid = 0, flush = 0, out_ready = 1;
  logic in_ready, out_valid, empty;
  logic [15:0] in_addr = 0, in_word = 0;
  logic [1:0] in_wmask = 0;
  lc3b_line_tag out_tag;
  lc3b_line out_data;
  lc3b_line_mask out_bmask;
  exp_t sb[$];
  exp_t e;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  write_merge_buffer #(.LINE_BYTES(16), .WORD_BYTES(2), .ADDR_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_word(in_word), .in_wmask(in_wmask), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_data(out_data), .out_bmask(out_bmask), .empty(empty)
  );
  always @(negedge clk) if (reset_n && out_valid && out_ready) begin
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_drain: got tag %h data %h bmask %h, none expected", out_tag, out_data, out_bmask);
    end else begin
      e = sb.pop_front();
      if ({out_tag, out_data, out_bmask} !== e) begin
        fails++;
        $display("FAIL drain: got tag %h data %h bmask %h, expected tag %h data %h bmask %h",
                 out_tag, out_data, out_bmask, e.tag, e.data, e.bmask);
      end
    end
  end
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic store(input logic [15:0] a, input logic [15:0] w, input logic [1:0] m);
    int n = 0;
    in_valid = 1;
    in_addr = a;
    in_word = w;
    in_wmask = m;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL store_timeout: addr %h never accepted, in_ready %b expected 1", a, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic do_flush();
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
  endtask
  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check({name, "_drained"}, sb.size(), 0);
    @(posedge clk);
    #1 check({name, "_empty_after"}, empty, 1);
  endtask
  initial begin
    @(negedge clk);
    check("in_ready_in_reset", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_empty", empty, 1);
    check("rst_bmask", out_bmask, 0);
    check("rst_data", out_data, 0);
    check("rst_tag", out_tag, 0);
    store(16'h7000, 16'h1234, 2'b00);
    @(negedge clk);
    check("noop_store_empty", empty, 1);
    sb.push_back('{12'h100, 128'hBEEF, 16'h0003});
    store(16'h1000, 16'hBEEF, 2'b11);
    @(negedge clk);
    check("merge_latency_bmask", out_bmask, 16'h0003);
    check("merge_latency_data", out_data, 128'hBEEF);
    do_flush();
    wait_drain("t1");
    sb.push_back('{12'h200, 128'h9A000000_00000000_00005678_00001200, 16'h8032});
    store(16'h2001, 16'h0012, 2'b01);
    store(16'h2004, 16'h5678, 2'b11);
    store(16'h200E, 16'h9A00, 2'b10);
    do_flush();
    wait_drain("t2");
    sb.push_back('{12'h300, {8'hBB, 120'h0}, 16'h8000});
    store(16'h300F, 16'hAABB, 2'b11);
    do_flush();
    wait_drain("t3");
    sb.push_back('{12'h400, 128'h1111, 16'h0003});
    store(16'h4000, 16'h1111, 2'b11);
    out_ready = 0;
    in_valid = 1;
    in_addr = 16'h5000;
    in_word = 16'h2222;
    in_wmask = 2'b11;
    @(negedge clk);
    check("mismatch_in_ready", in_ready, 0);
    check("mismatch_no_valid_yet", out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_data_stable", out_data, 128'h1111);
    end
    @(posedge clk);
    #1 out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check("realloc_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    check("realloc_tag", out_tag, 12'h500);
    check("realloc_bmask", out_bmask, 16'h0003);
    check("realloc_not_empty", empty, 0);
    sb.push_back('{12'h500, 128'h2222, 16'h0003});
    do_flush();
    wait_drain("t4");
    sb.push_back('{12'h800, 128'h1357, 16'h0003});
    store(16'h8000, 16'h1357, 2'b11);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1 check($sformatf("timeout_edge%0d", k), out_valid, k == 5);
    end
    wait_drain("t5a");
    sb.push_back('{12'h900, 128'h2222_1111, 16'h000F});
    store(16'h9000, 16'h1111, 2'b11);
    repeat (3) @(posedge clk);
    #1 store(16'h9002, 16'h2222, 2'b11);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1 check($sformatf("restart_edge%0d", k), out_valid, k == 5);
    end
    wait_drain("t5b");
    out_ready = 0;
    store(16'h6000, 16'h3333, 2'b11);
    do_flush();
    @(negedge clk);
    check("pre_reset_valid", out_valid, 1);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    out_ready = 1;
    check("post_reset_valid", out_valid, 0);
    check("post_reset_empty", empty, 1);
    check("post_reset_bmask", out_bmask, 0);
    sb.push_back('{12'h600, 128'h44_0000, 16'h0004});
    store(16'h6002, 16'h0044, 2'b01);
    do_flush();
    wait_drain("t6");
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/write_merge_buffer.md
# write_merge_buffer

Single-line write-coalescing buffer between the datapath store port and the L1 data cache write path. Successive sub-line stores to the same line are merged into one line-wide image with a per-byte dirty mask. The image is drained as one line-write transaction on a tag change, an explicit flush, or an idle timeout. Line size, store width and timeout are parametrised; the current configuration is 16-byte lines and 2-byte stores.

## Interface
- LINE_BYTES, 16, bytes per line; power of two, ≥ WORD_BYTES
- WORD_BYTES, 2, bytes per store word; power of two
- ADDR_W, 16, byte address width
- TIMEOUT, 16, idle cycles before auto-drain; 0 disables the timer
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  reset, synchronous and active-low
- in_valid  in  1  store request valid
- in_ready  out  1  store accepted when in_valid && in_ready
- in_addr  in  ADDR_W  byte address of word byte 0
- in_word  in  8*WORD_BYTES  store data; byte i = in_word[8i+7:8i]
- in_wmask  in  WORD_BYTES  byte enables
- flush  in  1  level request to drain the current line
- out_valid  out  1  line-write valid
- out_ready  in  1  downstream accepts the line
- out_tag  out  ADDR_W-log2(LINE_BYTES)  line address
- out_data  out  8*LINE_BYTES  merged line image
- out_bmask  out  LINE_BYTES  bytes written since allocation
- empty  out  1  buffer holds no line (state EMPTY)

## Operation
- Offset is in_addr[log2(LINE_BYTES)-1:0]; tag is the remaining upper bits.
- Byte i of in_word goes to line byte offset+i when in_wmask[i]=1. That byte's out_bmask bit is set. Other bytes are unchanged.
- If offset+i ≥ LINE_BYTES, byte i is discarded with no mask bit and no wrap. Example: WORD_BYTES=2, offset 15, mask 11 writes only byte 15.
- An accepted store with in_wmask=0 is a no-op. It causes no allocation and no timer reset.
- States:
  - EMPTY:
    - in_ready=1.
    - A store with non-zero mask allocates: tag is loaded, data and mask are cleared and then merged, and the state goes to MERGING.
  - MERGING:
    - in_ready=1 iff in_addr tag equals the held tag. The in_addr → in_ready path is combinational.
    - A matching store merges and resets the idle counter.
    - A valid mismatching store is held off (in_ready=0) and the state goes to DRAIN.
    - flush=1, or idle counter == TIMEOUT (TIMEOUT≠0), moves the state to DRAIN.
  - DRAIN:
    - in_ready=0 and out_valid=1.
    - out_tag, out_data and out_bmask stay stable until out_ready.
    - On the handshake, the state goes to EMPTY.
- Simultaneous events:
  - Matching store plus flush in MERGING: the store merges first, then the state goes to DRAIN with the store included.
  - Store plus flush in EMPTY: allocate, then DRAIN with that line.
  - flush in EMPTY alone: ignored.
  - flush in DRAIN: ignored.
- The idle counter saturates at TIMEOUT and is cleared on allocation and on each merge.

## Timing
- All outputs are registered from state, except in_ready, which is a combinational function of state and in_addr.
- Reset (reset_n=0 at an edge) gives: state EMPTY, out_valid=0, out_bmask=0, out_data=0, out_tag=0, empty=1, counter=0. in_ready=0 while reset_n=0.
- Reset during DRAIN discards the line; out_valid is 0 the following cycle.
- Merge latency: a store accepted at edge N is visible in out_data/out_bmask after edge N.
- Drain latency:
  - The flush or mismatch decision is taken at edge N; out_valid=1 from edge N.
  - With out_ready=1, the handshake completes at edge N+1 and empty=1 after it.
- A held-off mismatching store is accepted (allocating) at the first edge in EMPTY. This gives a minimum 2-cycle stall with out_ready=1.
- Auto-drain: with no accepted stores, out_valid rises TIMEOUT+1 edges after the last merge.

## Structure
- Add to lc3b_types:
  - lc3b_line (128-bit)
  - lc3b_line_mask (16-bit)
  - lc3b_line_tag
  - enum wmb_state_t {WMB_EMPTY, WMB_MERGING, WMB_DRAIN}
- Sub-module line_byte_merge is purely combinational. It is parametrised by LINE_BYTES and WORD_BYTES.
  - Inputs: offset, line, mask, word, wmask.
  - Outputs: merged line and merged mask.
  - Implemented as a generate loop over line bytes; it replaces the enumerated per-offset insert.

## Test plan
- Reset, then store addr 0x1000, word 0xBEEF, mask 11, then flush → out_tag 0x100, out_data[15:0]=0xBEEF, out_bmask 0x0003, empty=1 after the handshake.
- Stores to 0x2001 (mask 01, 0xxx12), 0x2004 (mask 11, 0x5678), 0x200E (mask 10, 0x9Axx), then flush → out_bmask 0x8032, byte1=0x12, bytes4–5=0x78/0x56, byte15=0x9A.
- Store 0x300F with mask 11, word 0xAABB, then flush → byte15=0xBB, out_bmask 0x8000, nothing else written.
- Store to 0x4000, then a store to 0x5000 with out_ready held low 3 cycles:
  - in_ready=0 throughout, and out_data stays stable.
  - After the handshake, the second store allocates tag 0x500.
- TIMEOUT=4: one store, then idle → out_valid rises exactly 5 edges later. A merge at idle cycle 3 restarts the count.
- Assert reset_n=0 during DRAIN with out_ready=0 → out_valid=0, empty=1, and the next store allocates fresh with out_bmask containing only its own bytes.
